// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared definitions for the LED pattern engine.
//   mode_e    : pattern mode encodings (MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE, MODE_FILL)
//   phase_e   : bounce/fill half-pass direction (PH_FWD, PH_REV)
//   pass_len  : steps in one full pass for a mode at a given LED count
//   half_len  : step count at which bounce/fill switch to the reverse phase
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'd0,
    MODE_ROT_R  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic {
    PH_FWD = 1'b0,
    PH_REV = 1'b1
  } phase_e;

  function automatic int unsigned pass_len(mode_e m, int unsigned w);
    case (m)
      MODE_ROT_L, MODE_ROT_R: return w;
      MODE_BOUNCE:            return 2 * (w - 1);
      default:                return 2 * w;
    endcase
  endfunction

  // For rotate modes this equals the pass length, so the wrap wins and the
  // phase never leaves PH_FWD.
  function automatic int unsigned half_len(mode_e m, int unsigned w);
    case (m)
      MODE_BOUNCE: return w - 1;
      default:     return w;
    endcase
  endfunction

endpackage

// File: rtl/led_pass_counter.sv
// led_pass_counter: saturating 16-bit pass counter.
//   clk, reset : clock, asynchronous active-high reset (clears count)
//   i_inc      : increment request (one per completed pass)
//   o_count    : current count, sticks at 16'hFFFF
module led_pass_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: WIDTH-bit LED pattern generator (rotate-left,
// rotate-right, bounce, fill/drain) stepping once per qualified tick.
//   clk, reset   : clock, asynchronous active-high reset
//   tick         : step enable (ignored while pause is high)
//   pause        : level hold of leds/step/phase; load and mode change still act
//   mode         : 0 rot-left, 1 rot-right, 2 bounce, 3 fill/drain
//   load         : strobe loading load_pattern and restarting the pass
//   load_pattern : pattern written on load
//   leds         : registered LED pattern
//   pass_done    : one-cycle strobe coincident with the final step of a pass
//   pass_count   : saturating pass count when LED_PASS_COUNT_EN is defined,
//                  otherwise tied to zero
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  INIT_PATTERN = WIDTH'(8'b10101010)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pattern,
  output logic [WIDTH-1:0] leds,
  output logic             pass_done,
  output logic [15:0]      pass_count
);

  localparam int unsigned SW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] r_leds,      w_leds;
  logic [SW-1:0]    r_step,      w_step;
  phase_e           r_phase,     w_phase;
  mode_e            r_mode_q,    w_mode_q;
  logic             r_pass_done, w_pass_done;

  mode_e            w_mode;
  logic [31:0]      w_step_inc;
  logic [31:0]      w_plen;
  logic [31:0]      w_half;
  logic [WIDTH-1:0] w_rotl;
  logic [WIDTH-1:0] w_rotr;
  logic [WIDTH-1:0] w_seed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds      <= INIT_PATTERN;
      r_step      <= '0;
      r_phase     <= PH_FWD;
      r_mode_q    <= MODE_ROT_L;
      r_pass_done <= 1'b0;
    end else begin
      r_leds      <= w_leds;
      r_step      <= w_step;
      r_phase     <= w_phase;
      r_mode_q    <= w_mode_q;
      r_pass_done <= w_pass_done;
    end
  end

  always_comb begin
    w_leds      = r_leds;
    w_step      = r_step;
    w_phase     = r_phase;
    w_mode_q    = r_mode_q;
    w_pass_done = 1'b0;

    w_mode     = mode_e'(mode);
    w_step_inc = 32'(r_step) + 32'd1;
    w_plen     = pass_len(r_mode_q, WIDTH);
    w_half     = half_len(r_mode_q, WIDTH);
    w_rotl     = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
    w_rotr     = {r_leds[0], r_leds[WIDTH-1:1]};

    case (w_mode)
      MODE_ROT_L, MODE_ROT_R: w_seed = INIT_PATTERN;
      MODE_BOUNCE:            w_seed = WIDTH'(1);
      default:                w_seed = '0;
    endcase

    if (load) begin
      // mode_q tracks mode here so a coincident mode change does not reseed
      w_leds   = load_pattern;
      w_step   = '0;
      w_phase  = PH_FWD;
      w_mode_q = w_mode;
    end else if (w_mode != r_mode_q) begin
      w_leds   = w_seed;
      w_step   = '0;
      w_phase  = PH_FWD;
      w_mode_q = w_mode;
    end else if (tick && !pause) begin
      unique case (r_mode_q)
        MODE_ROT_L:  w_leds = w_rotl;
        MODE_ROT_R:  w_leds = w_rotr;
        MODE_BOUNCE: w_leds = (r_phase == PH_FWD) ? w_rotl : w_rotr;
        MODE_FILL:   w_leds = {r_leds[WIDTH-2:0], (r_phase == PH_FWD)};
      endcase
      if (w_step_inc == w_plen) begin
        w_step      = '0;
        w_phase     = PH_FWD;
        w_pass_done = 1'b1;
      end else begin
        w_step = SW'(w_step_inc);
        if (w_step_inc == w_half) begin
          w_phase = PH_REV;
        end
      end
    end
  end

  assign leds      = r_leds;
  assign pass_done = r_pass_done;

`ifdef LED_PASS_COUNT_EN
  led_pass_counter u_pass_counter (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (r_pass_done),
    .o_count (pass_count)
  );
`else
  assign pass_count = '0;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: table-driven directed vectors, hand-written reset
// and pass-count sequences, and randomized stimulus against a step-count
// reference model of led_pattern_engine (WIDTH=8, INIT_PATTERN=8'hAA).
module tb_led_pattern_engine;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, pause, load;
  logic [1:0] mode;
  logic [7:0] load_pattern;
  logic [7:0] leds;
  logic       pass_done;
  logic [15:0] pass_count;

  int n_vec = 0;
  int n_err = 0;

  led_pattern_engine #(.WIDTH(8), .INIT_PATTERN(8'hAA)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .pause        (pause),
    .mode         (mode),
    .load         (load),
    .load_pattern (load_pattern),
    .leds         (leds),
    .pass_done    (pass_done),
    .pass_count   (pass_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       pause;
    logic [1:0] mode;
    logic       load;
    logic [7:0] lp;
    logic [7:0] exp_leds;
    logic       exp_done;
  } vec_t;

  vec_t tbl[$];

  // Reference model: pass position counted in steps, direction derived
  // from which half of the pass the step count lies in.
  int m_leds, m_step, m_mode, m_cnt;
  bit m_done;

  function automatic int exp_cnt(int c);
`ifdef LED_PASS_COUNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_leds = 'hAA; m_step = 0; m_mode = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic model_clock(bit t, bit p, int md, bit ld, int lp);
    int plen;
    m_done = 0;
    if (ld) begin
      m_leds = lp; m_step = 0; m_mode = md;
    end else if (md != m_mode) begin
      m_mode = md; m_step = 0;
      m_leds = (md <= 1) ? 'hAA : (md == 2) ? 1 : 0;
    end else if (t && !p) begin
      plen = (md <= 1) ? W : (md == 2) ? 2 * (W - 1) : 2 * W;
      case (md)
        0: m_leds = ((m_leds * 2) % 256) + (m_leds / 128);
        1: m_leds = (m_leds / 2) + (m_leds % 2) * 128;
        2: if (m_step < W - 1) m_leds = ((m_leds * 2) % 256) + (m_leds / 128);
           else                m_leds = (m_leds / 2) + (m_leds % 2) * 128;
        default: m_leds = ((m_leds * 2) % 256) + ((m_step < W) ? 1 : 0);
      endcase
      m_step++;
      if (m_step == plen) begin
        m_step = 0;
        m_done = 1;
        if (m_cnt < 'hFFFF) m_cnt++;
      end
    end
  endtask

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit t, bit p, logic [1:0] md, bit ld, logic [7:0] lp);
    tick = t; pause = p; mode = md; load = ld; load_pattern = lp;
  endtask

  function automatic void add(bit t, bit p, int md, bit ld, int lp, int el, bit ed);
    vec_t v;
    v.tick = t; v.pause = p; v.mode = 2'(md); v.load = ld;
    v.lp = 8'(lp); v.exp_leds = 8'(el); v.exp_done = ed;
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    drive(0, 0, 2'd0, 0, 8'h00);
    reset = 1'b1;
    #12;
    reset = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  int dones;

  initial begin
    drive(0, 0, 2'd0, 0, 8'h00);
    reset = 1'b1;
    #3;
    check("reset_leds", leds, 'hAA);
    check("reset_done", pass_done, 0);
    check("reset_count", pass_count, 0);
    #9;
    reset = 1'b0;
    @(negedge clk);

    // ---- directed table ----
    for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 0, (i % 2 == 0) ? 'h55 : 'hAA, i == 7);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, (i % 2 == 0) ? 'h55 : 'hAA, 0);
    add(0, 0, 1, 0, 0, 'hAA, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, (i % 2 == 0) ? 'h55 : 'hAA, 0);
    add(0, 0, 2, 0, 0, 'h01, 0);
    for (int i = 0; i < 14; i++) add(1, 0, 2, 0, 0, (i < 7) ? (1 << (i + 1)) : (1 << (13 - i)), i == 13);
    add(1, 0, 3, 0, 0, 'h00, 0);
    for (int i = 0; i < 16; i++) add(1, 0, 3, 0, 0, (i < 8) ? ((1 << (i + 1)) - 1) : (('hFF << (i - 7)) & 'hFF), i == 15);
    add(0, 0, 0, 0, 0, 'hAA, 0);
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 'hAA, 0);
    add(0, 1, 0, 1, 'h0F, 'h0F, 0);
    add(1, 0, 0, 0, 0, 'h1E, 0);
    add(1, 1, 2, 1, 'h81, 'h81, 0);  // load beats coincident mode change
    add(1, 0, 2, 0, 0, 'h03, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].tick, tbl[i].pause, tbl[i].mode, tbl[i].load, tbl[i].lp);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_leds", i), leds, tbl[i].exp_leds);
      check($sformatf("tbl%0d_done", i), pass_done, tbl[i].exp_done);
    end

    // ---- three passes then reset mid-pass ----
    do_reset();
    dones = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1, 0, 2'd0, 0, 8'h00);
      @(posedge clk); #1;
      if (pass_done) dones++;
    end
    check("three_pass_dones", dones, 3);
    drive(0, 0, 2'd0, 0, 8'h00);
    @(posedge clk); #1;
    check("three_pass_count", pass_count, exp_cnt(3));
    drive(1, 0, 2'd0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("midpass_leds", leds, 'h55);
    #2 reset = 1'b1;
    #1;
    check("async_rst_leds", leds, 'hAA);
    check("async_rst_count", pass_count, 0);
    check("async_rst_done", pass_done, 0);
    @(negedge clk);
    reset = 1'b0;
    // the partial pass must not resume: 8 fresh ticks complete exactly one pass
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (pass_done) dones++;
      if (i == 6) check("post_rst_no_early_done", dones, 0);
    end
    check("post_rst_pass", dones, 1);
    check("post_rst_leds", leds, 'hAA);

    // ---- randomized against model ----
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bit t, p, ld;
      int md, lp;
      t  = ($urandom_range(0, 9) < 7);
      p  = ($urandom_range(0, 9) < 2);
      ld = ($urandom_range(0, 29) == 0);
      md = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : m_mode;
      lp = int'($urandom_range(0, 255));
      drive(t, p, 2'(md), ld, 8'(lp));
      @(posedge clk); #1;
      model_clock(t, p, md, ld, lp);
      check("rnd_leds", leds, m_leds);
      check("rnd_done", pass_done, int'(m_done));
      check("rnd_count", pass_count, exp_cnt(m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
